// File: rtl/inv_shift_rows_serial.sv
// Byte-serial AES (Inv)ShiftRows receiver: each accepted byte lands directly in its
// permuted slot of an assembly buffer; finished blocks move to a held 128-bit output register.
module inv_shift_rows_serial #(
    parameter bit INVERSE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_byte,
    input  logic         in_sof,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_text,
    output logic         sync_err
);

    logic [3:0]   cnt;
    logic         asm_full;
    logic [127:0] asm_buf;
    logic [127:0] asm_next;
    logic         accept;
    logic         resync;
    logic         last_byte;
    logic         slot_free;
    logic [3:0]   idx;
    logic [3:0]   dest;

    // Byte k = 4*c + r moves to column (c+r) for the inverse, (c-r) for the forward permutation.
    function automatic logic [3:0] dest_of(input logic [3:0] k);
        logic [1:0] r;
        logic [1:0] c;
        logic [1:0] cd;
        r  = k[1:0];
        c  = k[3:2];
        cd = INVERSE ? (c + r) : (c - r);
        return {cd, r};
    endfunction

    assign in_ready  = ~asm_full;
    assign accept    = in_valid & in_ready;
    assign resync    = in_sof & (cnt != 4'd0);
    assign idx       = resync ? 4'd0 : cnt;
    assign dest      = dest_of(idx);
    assign last_byte = accept & (idx == 4'd15);
    assign slot_free = ~out_valid | out_ready;

    // The assembly word with the incoming byte merged, so the 16th byte can bypass straight out.
    always_comb begin
        asm_next = asm_buf;
        asm_next[{dest, 3'b000} +: 8] = in_byte;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            asm_buf <= asm_next;
        end
    end

    // A completed block goes straight to the output when the slot is free, otherwise it parks
    // in the assembly buffer (asm_full) and input stalls until the consumer drains the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 4'd0;
            asm_full  <= 1'b0;
            out_valid <= 1'b0;
            out_text  <= '0;
            sync_err  <= 1'b0;
        end else begin
            sync_err <= accept & resync;
            if (accept) begin
                cnt <= idx + 4'd1;
            end
            if (last_byte && slot_free) begin
                out_text  <= asm_next;
                out_valid <= 1'b1;
            end else if (asm_full && slot_free) begin
                out_text  <= asm_buf;
                out_valid <= 1'b1;
                asm_full  <= 1'b0;
            end else begin
                if (last_byte) begin
                    asm_full <= 1'b1;
                end
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// Directed bench for inv_shift_rows_serial: placement in both directions, backpressure,
// resync, reset mid-block and a forward->inverse round trip with random gaps.
module tb_inv_shift_rows_serial;

    localparam int RT_BLOCKS = 1000;
    localparam int INV_DEST [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
    localparam int FWD_DEST [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

    logic clk;
    logic rst;

    logic         m_in_valid, m_in_ready, m_in_sof, m_out_valid, m_out_ready, m_sync_err;
    logic [7:0]   m_in_byte;
    logic [127:0] m_out_text;
    logic         f_in_valid, f_in_ready, f_in_sof, f_out_valid, f_out_ready, f_sync_err;
    logic [7:0]   f_in_byte;
    logic [127:0] f_out_text;
    logic         r_in_valid, r_in_ready, r_in_sof, r_out_valid, r_out_ready, r_sync_err;
    logic [7:0]   r_in_byte;
    logic [127:0] r_out_text;

    int checkCount = 0;
    int errorCount = 0;
    int syncPulses = 0;
    int rtDone = 0;
    logic [127:0] sentQ[$];

    inv_shift_rows_serial #(.INVERSE(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_byte(m_in_byte),
        .in_sof(m_in_sof), .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_text(m_out_text), .sync_err(m_sync_err));

    inv_shift_rows_serial #(.INVERSE(1'b0)) dut_fwd (
        .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready), .in_byte(f_in_byte),
        .in_sof(f_in_sof), .out_valid(f_out_valid), .out_ready(f_out_ready),
        .out_text(f_out_text), .sync_err(f_sync_err));

    inv_shift_rows_serial #(.INVERSE(1'b1)) dut_rt (
        .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready), .in_byte(r_in_byte),
        .in_sof(r_in_sof), .out_valid(r_out_valid), .out_ready(r_out_ready),
        .out_text(r_out_text), .sync_err(r_sync_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_sync_err) syncPulses++;
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] permute(input logic [127:0] blk, input bit inv);
        logic [127:0] res;
        res = '0;
        for (int k = 0; k < 16; k++) begin
            res[(inv ? INV_DEST[k] : FWD_DEST[k]) * 8 +: 8] = blk[k * 8 +: 8];
        end
        return res;
    endfunction

    function automatic logic [127:0] makeBlock(input logic [7:0] base);
        logic [127:0] res;
        for (int k = 0; k < 16; k++) res[k * 8 +: 8] = base + 8'(k);
        return res;
    endfunction

    function automatic logic readyOf(input int sel);
        case (sel)
            0:       return m_in_ready;
            1:       return f_in_ready;
            default: return r_in_ready;
        endcase
    endfunction

    task automatic driveIn(input int sel, input logic v, input logic [7:0] b, input logic sof);
        case (sel)
            0:       begin m_in_valid = v; m_in_byte = b; m_in_sof = sof; end
            1:       begin f_in_valid = v; f_in_byte = b; f_in_sof = sof; end
            default: begin r_in_valid = v; r_in_byte = b; r_in_sof = sof; end
        endcase
    endtask

    // Called just after a negedge; returns at the negedge following the accepting posedge.
    task automatic applyStimulus(input int sel, input logic [7:0] b, input logic sof, output bit ok);
        int waitCnt;
        waitCnt = 0;
        driveIn(sel, 1'b1, b, sof);
        while (!readyOf(sel) && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!readyOf(sel)) begin
            checkOutput("in_ready timeout", {127'd0, readyOf(sel)}, 128'd1);
            driveIn(sel, 1'b0, 8'h00, 1'b0);
            ok = 1'b0;
            return;
        end
        @(negedge clk);
        ok = 1'b1;
    endtask

    task automatic sendBlock(input int sel, input logic [127:0] blk);
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < 16 && ok; k++) applyStimulus(sel, blk[k * 8 +: 8], k == 0, ok);
        driveIn(sel, 1'b0, 8'h00, 1'b0);
    endtask

    bit okFlag;
    logic [127:0] expD;

    initial begin
        rst = 1'b1;
        driveIn(0, 1'b0, 8'h00, 1'b0);
        driveIn(1, 1'b0, 8'h00, 1'b0);
        driveIn(2, 1'b0, 8'h00, 1'b0);
        m_out_ready = 1'b0;
        f_out_ready = 1'b0;
        r_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset in_ready", {127'd0, m_in_ready}, 128'd1);
        checkOutput("reset out_valid", {127'd0, m_out_valid}, 128'd0);
        checkOutput("reset out_text", m_out_text, 128'd0);
        checkOutput("reset sync_err", {127'd0, m_sync_err}, 128'd0);

        // Inverse placement of 00..0F, then the output drains on out_ready
        m_out_ready = 1'b1;
        sendBlock(0, makeBlock(8'h00));
        checkOutput("inv out_valid", {127'd0, m_out_valid}, 128'd1);
        checkOutput("inv out_text", m_out_text, 128'h0306090C0F0205080B0E0104070A0D00);
        @(negedge clk);
        checkOutput("inv drain", {127'd0, m_out_valid}, 128'd0);

        f_out_ready = 1'b1;
        sendBlock(1, makeBlock(8'h00));
        checkOutput("fwd out_valid", {127'd0, f_out_valid}, 128'd1);
        checkOutput("fwd out_text", f_out_text, 128'h0B06010C07020D08030E09040F0A0500);
        @(negedge clk);
        checkOutput("fwd drain", {127'd0, f_out_valid}, 128'd0);
        f_out_ready = 1'b0;

        // Backpressure across three blocks
        m_out_ready = 1'b0;
        sendBlock(0, makeBlock(8'h10));
        sendBlock(0, makeBlock(8'h20));
        checkOutput("bp in_ready low", {127'd0, m_in_ready}, 128'd0);
        checkOutput("bp hold A", m_out_text, permute(makeBlock(8'h10), 1'b1));
        repeat (3) @(negedge clk);
        checkOutput("bp still held", m_out_text, permute(makeBlock(8'h10), 1'b1));
        checkOutput("bp still valid", {127'd0, m_out_valid}, 128'd1);
        m_out_ready = 1'b1;
        @(negedge clk);
        m_out_ready = 1'b0;
        checkOutput("bp load B valid", {127'd0, m_out_valid}, 128'd1);
        checkOutput("bp load B", m_out_text, permute(makeBlock(8'h20), 1'b1));
        checkOutput("bp in_ready back", {127'd0, m_in_ready}, 128'd1);
        sendBlock(0, makeBlock(8'h30));
        checkOutput("bp C parked", {127'd0, m_in_ready}, 128'd0);
        checkOutput("bp B held", m_out_text, permute(makeBlock(8'h20), 1'b1));
        m_out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp load C", m_out_text, permute(makeBlock(8'h30), 1'b1));
        @(negedge clk);
        checkOutput("bp final drain", {127'd0, m_out_valid}, 128'd0);
        checkOutput("no sync_err so far", syncPulses, 0);

        // Resync: partial block of 7 bytes abandoned by a fresh in_sof
        for (int k = 0; k < 7; k++) applyStimulus(0, 8'h50 + 8'(k), k == 0, okFlag);
        applyStimulus(0, 8'hA0, 1'b1, okFlag);
        checkOutput("sync_err pulse", {127'd0, m_sync_err}, 128'd1);
        for (int k = 1; k < 16; k++) begin
            applyStimulus(0, 8'hA0 + 8'(k), 1'b0, okFlag);
            if (k == 1) checkOutput("sync_err one cycle", {127'd0, m_sync_err}, 128'd0);
        end
        driveIn(0, 1'b0, 8'h00, 1'b0);
        checkOutput("resync valid", {127'd0, m_out_valid}, 128'd1);
        checkOutput("resync text", m_out_text, permute(makeBlock(8'hA0), 1'b1));
        checkOutput("resync low bytes", {112'd0, m_out_text[15:0]}, 128'h0000ADA0);
        checkOutput("sync_err count", syncPulses, 1);

        // Reset mid-block with a pending output
        @(negedge clk);
        m_out_ready = 1'b0;
        sendBlock(0, makeBlock(8'h60));
        for (int k = 0; k < 9; k++) applyStimulus(0, 8'h70 + 8'(k), k == 0, okFlag);
        driveIn(0, 1'b0, 8'h00, 1'b0);
        checkOutput("pending before rst", {127'd0, m_out_valid}, 128'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst out_valid", {127'd0, m_out_valid}, 128'd0);
        checkOutput("rst out_text", m_out_text, 128'd0);
        checkOutput("rst in_ready", {127'd0, m_in_ready}, 128'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post rst in_ready", {127'd0, m_in_ready}, 128'd1);
        m_out_ready = 1'b1;
        sendBlock(0, makeBlock(8'hC0));
        checkOutput("post rst text", m_out_text, permute(makeBlock(8'hC0), 1'b1));

        // Round trip: random blocks through the forward then the inverse instance
        fork
            begin : producer
                bit ok;
                logic [127:0] blk;
                ok = 1'b1;
                for (int n = 0; n < RT_BLOCKS && ok; n++) begin
                    for (int k = 0; k < 16; k++) blk[k * 8 +: 8] = 8'($urandom_range(0, 255));
                    sentQ.push_back(blk);
                    for (int k = 0; k < 16 && ok; k++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            driveIn(1, 1'b0, 8'h00, 1'b0);
                            @(negedge clk);
                        end
                        applyStimulus(1, blk[k * 8 +: 8], k == 0, ok);
                    end
                end
                driveIn(1, 1'b0, 8'h00, 1'b0);
            end
            begin : bridge
                bit ok;
                int w;
                logic [127:0] cap;
                ok = 1'b1;
                for (int n = 0; n < RT_BLOCKS && ok; n++) begin
                    w = 0;
                    while (!f_out_valid && w < 400) begin
                        @(negedge clk);
                        w++;
                    end
                    if (!f_out_valid) begin
                        checkOutput("fwd out_valid timeout", {127'd0, f_out_valid}, 128'd1);
                        ok = 1'b0;
                    end else begin
                        cap = f_out_text;
                        for (int k = 0; k < 16 && ok; k++) begin
                            if ($urandom_range(0, 3) == 0) begin
                                driveIn(2, 1'b0, 8'h00, 1'b0);
                                @(negedge clk);
                            end
                            applyStimulus(2, cap[k * 8 +: 8], k == 0, ok);
                        end
                        driveIn(2, 1'b0, 8'h00, 1'b0);
                        f_out_ready = 1'b1;
                        @(negedge clk);
                        f_out_ready = 1'b0;
                    end
                end
            end
            begin : consumer
                int cyc;
                logic [127:0] expBlk;
                cyc = 0;
                while (rtDone < RT_BLOCKS && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    r_out_ready = ($urandom_range(0, 3) != 0);
                    if (r_out_valid && r_out_ready) begin
                        expBlk = '0;
                        if (sentQ.size() > 0) expBlk = sentQ.pop_front();
                        checkOutput("round trip", r_out_text, expBlk);
                        rtDone++;
                    end
                end
                if (rtDone < RT_BLOCKS) checkOutput("round trip count", rtDone, RT_BLOCKS);
                r_out_ready = 1'b0;
            end
        join

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/inv_shift_rows_serial.md
Name: inv_shift_rows_serial

Overview:
Byte-serial AES InvShiftRows receiver for the low-area decryption datapath. It accepts state bytes one per cycle over a valid/ready stream and writes each byte directly into its permuted slot of a 128-bit assembly buffer. Completed blocks go to a double-buffered 128-bit output port with valid/ready. A parameter selects the forward ShiftRows permutation instead, so the same block serves the encrypt-side deserializer and round-trip checking.

Parameters:
INVERSE, 1, 1 = InvShiftRows placement; 0 = forward ShiftRows placement

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_byte valid
in_ready  output  1  block can accept in_byte this cycle
in_byte  input  8  state byte; byte k of a block occupies bits [8k+7:8k] of the 128-bit state
in_sof  input  1  marks byte 0 of a block; sampled only on accept
out_valid  output  1  out_text holds a complete permuted block
out_ready  input  1  downstream accepts out_text
out_text  output  128  permuted state, byte 0 at [7:0]
sync_err  output  1  one-cycle pulse: in_sof seen mid-block

Behaviour:
- Byte index k = 4*c + r, where r = row and c = column.
- Placement of input byte (r,c) into output byte (r,c'):
  - INVERSE=1: c' = (c+r) mod 4, so out(r,c) = in(r,(c-r) mod 4).
  - INVERSE=0: c' = (c-r) mod 4, so out(r,c) = in(r,(c+r) mod 4).
- INVERSE=1 destination map for k=0..15: 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11.
- Accept = in_valid & in_ready.
- Byte counter cnt (4 bits):
  - On accept, the byte is written to asm[dest(cnt)] and cnt increments, wrapping 15 -> 0.
  - The byte accepted at cnt=0 is byte 0, whether or not in_sof is set.
- in_sof on accept with cnt != 0: the byte is written as byte 0, cnt <= 1, and sync_err pulses high the next cycle. The partial block is abandoned; its stale slots are overwritten by the restarted block.
- Output slot "free" means out_valid=0, or out_valid=1 and out_ready=1 in the same cycle.
- Accept at cnt=15 with the slot free: the full word (byte 15 merged) loads into out_text, out_valid=1 next cycle, and cnt returns to 0. Latency from last-byte accept to out_valid is 1 cycle.
- Accept at cnt=15 with the slot not free: asm_full=1 and in_ready=0. When the slot frees, asm loads into out_text the next cycle and asm_full clears in that same cycle.
- in_ready = ~asm_full (registered state, no combinational path from out_ready).
- out_valid behaviour:
  - Falls on out_ready when no new block loads that cycle.
  - Stays 1 when a drain and a load coincide; out_text then updates.
- out_text is held stable while out_valid=1 and out_ready=0.
- Sustained throughput is 1 block per 16 cycles with no bubbles while out_ready=1.
- Reset (asynchronous, any state, including mid-block or with a pending output):
  - cnt=0, asm_full=0, out_valid=0, out_text=0, sync_err=0.
  - in_ready=1 in the first cycle after rst deasserts.
  - No partial block survives reset.
- The assembly buffer needs no reset value; out_text must reset to 0.
- in_sof while asm_full=1 is not sampled, because no accept occurs.

Test Plan:
1. INVERSE=1, bytes 0x00..0x0F back-to-back, in_sof on the first byte, out_ready=1 -> out_valid on the cycle after byte 15 with out_text=128'h03060 90C0F020508 0B0E01040 70A0D00 (no spaces; byte-wise MSB first: 03 06 09 0C 0F 02 05 08 0B 0E 01 04 07 0A 0D 00). sync_err stays 0.
2. INVERSE=0 with the same stimulus -> out_text bytes MSB first: 0B 06 01 0C 07 02 0D 08 03 0E 09 04 0F 0A 05 00.
3. Backpressure: out_ready=0 while streaming three blocks ->
   - block 1 is held in out_text;
   - block 2 fills asm, then in_ready=0 after its 16th byte;
   - raising out_ready for 1 cycle drains block 1, loads block 2 next cycle, and in_ready returns to 1;
   - no bytes are lost or duplicated.
4. Resync: 7 bytes, then in_sof with 0xA0..0xAF -> sync_err pulses once. The output is the permutation of 0xA0..0xAF only, e.g. INVERSE=1 bytes [7:0]=A0, [15:8]=AD.
5. Assert rst for 1 cycle mid-block (cnt=9) with a pending out_valid=1 -> out_valid=0 and out_text=0 immediately. A following clean 16-byte block produces a correct result.
6. Round trip: random 16-byte blocks through INVERSE=0 then INVERSE=1 instances, with random in_valid/out_ready gaps -> the final output equals the original block, for 1000 blocks.
